// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM state encodings,
// funct3 access codes and the store lane helpers.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        DMC_IDLE = 2'd0,
        DMC_BUSY = 2'd1,
        DMC_RESP = 2'd2
    } dmc_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Unlisted store funct3 codes behave as SW.
    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_SB:   return 4'b0001 << off;
            F3_SH:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_SB:   return {4{wd[7:0]}};
            F3_SH:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic is_write, input logic [2:0] f3,
                                           input logic [1:0] off);
        logic is_byte;
        logic is_half;
        is_byte = is_write ? (f3 == F3_SB) : (f3 == F3_LB || f3 == F3_LBU);
        is_half = is_write ? (f3 == F3_SH) : (f3 == F3_LH || f3 == F3_LHU);
        if (is_byte) return 1'b0;
        if (is_half) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-organised data memory bus with a ready handshake; the controller is
// the master, the memory the slave.
interface data_mem_ctrl_if #(
    parameter int MEM_AW = 10
);
    logic              m_en;
    logic [3:0]        m_we;
    logic [MEM_AW-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_ready;

    modport master (output m_en, m_we, m_addr, m_wdata, input m_rdata, m_ready);
    modport slave  (input m_en, m_we, m_addr, m_wdata, output m_rdata, m_ready);
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and sign/zero-extends it
// according to the load funct3; unlisted codes return the whole word.
module load_extend
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    output logic [31:0] o_result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[8*i_byte_off +: 8];
    // Halves use only addr[1]; a misaligned half reads the aligned-down lane.
    assign w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        case (i_funct3)
            F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_result = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_result = {24'd0, w_byte};
            F3_LHU:  o_result = {16'd0, w_half};
            default: o_result = i_word;
        endcase
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage sequencer: IDLE -> BUSY (until m_ready) -> RESP, stalling the
// pipeline meanwhile. DATA_MEM_MISALIGN_TRAP_EN makes misaligned requests skip memory.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            resp_valid,
    output logic            stall,
    output logic            misaligned,
    data_mem_ctrl_if.master mem
);
    dmc_state_e r_state;
    dmc_state_e w_state_next;

    logic              r_is_write;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [MEM_AW-1:0] r_m_addr;
    logic [3:0]        r_m_we;
    logic [XLEN-1:0]   r_m_wdata;
    logic [XLEN-1:0]   r_rdata;

    logic            w_req;
    logic            w_take;
    logic            w_mis;
    logic            w_stall;
    logic            w_busy;
    logic            w_resp;
    logic [XLEN-1:0] w_load_ext;
    logic            w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_take        = (r_state == DMC_IDLE) && w_req;
    assign w_unused_addr = ^addr[XLEN-1:MEM_AW+2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_mis      = is_misaligned(mem_write, funct3, addr[1:0]);
    assign misaligned = w_resp & r_mis;
`else
    assign w_mis      = 1'b0;
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= DMC_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_busy       = 1'b0;
        w_resp       = 1'b0;
        case (r_state)
            DMC_IDLE: begin
                if (w_req) begin
                    w_stall      = 1'b1;
                    w_state_next = w_mis ? DMC_RESP : DMC_BUSY;
                end
            end
            DMC_BUSY: begin
                w_busy  = 1'b1;
                w_stall = 1'b1;
                if (mem.m_ready) w_state_next = DMC_RESP;
            end
            DMC_RESP: begin
                w_resp       = 1'b1;
                w_state_next = DMC_IDLE;
            end
            default: w_state_next = DMC_IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so the bus stays stable while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_write <= 1'b0;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_m_addr   <= '0;
            r_m_we     <= 4'd0;
            r_m_wdata  <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_take) begin
                r_is_write <= mem_write;
                r_funct3   <= funct3;
                r_off      <= addr[1:0];
                r_m_addr   <= addr[MEM_AW+1:2];
                r_m_we     <= mem_write ? store_strobe(funct3, addr[1:0]) : 4'd0;
                r_m_wdata  <= store_data(funct3, wdata);
            end
            if (w_busy && mem.m_ready && !r_is_write) r_rdata <= w_load_ext;
        end
    end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)         r_mis <= 1'b0;
        else if (w_take) r_mis <= w_mis;
    end
`endif

    load_extend u_load_extend (
        .i_word     (mem.m_rdata),
        .i_funct3   (r_funct3),
        .i_byte_off (r_off),
        .o_result   (w_load_ext)
    );

    // Strobes are only meaningful while the request is presented.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_we
            assign mem.m_we[gi] = r_m_we[gi] & w_busy;
        end
    endgenerate

    assign mem.m_en    = w_busy;
    assign mem.m_addr  = r_m_addr;
    assign mem.m_wdata = r_m_wdata;
    assign rdata       = r_rdata;
    assign resp_valid  = w_resp;
    assign stall       = w_stall & ~rst;
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sequencer between the RV32I pipeline's memory stage and a single-ported, word-organised data memory with a ready handshake.
- Consumes the decoder's mem_read/mem_write and the instruction funct3; drives memory enable, write strobes and address.
- Returns sign/zero-extended load data and a stall that freezes the pipeline until the access completes.

Parameters:
- MEM_AW, 10, word-address width of the data memory (m_addr width)
- XLEN, 32, data path width; only 32 supported

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  load request from control decode
- mem_write  in  1  store request from control decode
- funct3  in  3  instruction funct3 (access size/sign)
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- rdata  out  32  extended load result, valid while resp_valid=1
- resp_valid  out  1  one-cycle pulse: access complete
- stall  out  1  hold pipeline (combinational)
- misaligned  out  1  misaligned-access pulse (0 when feature compiled out)
- m_en  out  1  memory request, held until m_ready
- m_we  out  4  byte write strobes (0 for reads)
- m_addr  out  MEM_AW  word address = addr[MEM_AW+1:2]
- m_wdata  out  32  lane-replicated store data
- m_rdata  in  32  memory read word
- m_ready  in  1  memory accepted/completed request this cycle

Behaviour:
- Reset (rst=1 at edge): state=IDLE. rdata=0, resp_valid=0, misaligned=0, m_en=0, m_we=0, m_addr=0, m_wdata=0. stall=0 while rst=1. Reset in BUSY aborts the access; m_en drops the cycle after the reset edge.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req = mem_read|mem_write. If req, stall=1 combinationally.
  - At the edge, latch addr, funct3, wdata and is_write=mem_write (write wins if both are set), then go BUSY.
- BUSY:
  - m_en=1. m_addr/m_we/m_wdata come from registered values and stay stable until m_ready.
  - stall=1.
  - On m_ready=1: for a read, capture extend(m_rdata) into rdata. Go RESP.
  - Without m_ready, stay in BUSY indefinitely.
- RESP:
  - m_en=0, stall=0, resp_valid=1. The pipeline advances at this edge.
  - Next state IDLE unconditionally.
  - Back-to-back accesses therefore always pass through IDLE.
- Latency:
  - Minimum 3 cycles from request to resp_valid (IDLE, BUSY with m_ready=1, RESP).
  - Each m_ready-low cycle in BUSY adds one cycle.
- Store strobes / data:
  - SB (000): m_we=4'b0001<<addr[1:0], m_wdata={4{wdata[7:0]}}
  - SH (001): m_we=4'b0011<<{addr[1],1'b0}, m_wdata={2{wdata[15:0]}}
  - SW (010): m_we=4'b1111, m_wdata=wdata
  - Other funct3 values are treated as SW.
- Loads (byte lane selected by latched addr[1:0]):
  - LB 000 sign-extend byte, LH 001 sign-extend half (lane addr[1]), LW 010 word, LBU 100 zero-extend byte, LHU 101 zero-extend half.
  - Other funct3 values are treated as LW.
- rdata holds its value until the next read completes. Stores leave rdata unchanged.
- Misaligned (H with addr[0]=1; W with addr[1:0]!=0), feature off: access proceeds using aligned-down lane bits; no flag raised.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned request seen in IDLE goes directly to RESP.
  - No memory access: m_en never asserted.
  - misaligned=1 and resp_valid=1 in RESP. rdata unchanged.
  - stall=1 only in the IDLE cycle.
- Undefined: misaligned is tied to 0; behaviour as above.

Decomposition:
- Shared defines file (alongside the existing OPCODE_* macros):
  - F3_LB/LH/LW/LBU/LHU and F3_SB/SH/SW
  - DMC_IDLE/BUSY/RESP state encodings
- Sub-module: load_extend, a combinational block taking (word, funct3, byte_off) and returning the 32-bit result. Reused by any future cache fill path.

Test Plan:
- SW addr=0x104, wdata=0xDEADBEEF, m_ready=1 first BUSY cycle -> m_addr=0x41, m_we=1111, m_wdata=0xDEADBEEF; stall high 2 cycles; resp_valid on 3rd cycle.
- SB addr=0x003, wdata=0x000000A5 -> m_we=1000, m_wdata=0xA5A5A5A5.
- LB addr=0x002 with m_rdata=0x12F0_3456 -> rdata=0xFFFFFFF0. LBU same -> 0x000000F0. LHU addr=0x002 -> 0x000012F0.
- LW with m_ready held low 4 cycles -> m_en and m_addr stable for 5 BUSY cycles; stall high 6 cycles total; rdata=m_rdata.
- rst asserted in 2nd BUSY cycle -> next cycle state IDLE, m_en=0, resp_valid=0, rdata=0; a new request afterwards completes normally.
- With DATA_MEM_MISALIGN_TRAP_EN, LW addr=0x102 -> m_en never 1, misaligned=1 and resp_valid=1 in the same cycle; without the macro -> normal access with m_addr=0x40.
